uart_cmd_slave: RTL and testbench

UART_CMD_SLAVE -- requirements
Module: uart_cmd_slave

---
 rtl/uart_cmd_slave_pkg.sv | 17 +
 rtl/uart_cmd_slave_if.sv | 11 +
 rtl/uart_bit_timer.sv | 24 ++
 rtl/uart_cmd_slave.sv | 157 +++++++++++++++
 tb/tb_uart_cmd_slave.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_slave_pkg.sv
// Shared UART framing definitions: controller states, frame geometry, parity.
package uart_cmd_slave_pkg;

  localparam int FRAME_BITS = 11;              // start + 8 data + parity + stop
  localparam int DATA_BITS  = FRAME_BITS - 3;

  typedef enum logic [3:0] {
    IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, WAIT_B1, EXEC,
    RD_WAIT, TURN, TX_START, TX_DATA, TX_PAR, TX_STOP
  } state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/uart_cmd_slave_if.sv
// Register-bus side of the command slave: strobes, address, data.
interface uart_cmd_slave_if;
  logic       reg_we;
  logic       reg_re;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  modport master (output reg_we, reg_re, reg_addr, reg_wdata, input reg_rdata);
  modport slave  (input reg_we, reg_re, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with mid-bit and end-of-bit strobes.
module uart_bit_timer #(
  parameter int BR = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic mid,
  output logic fin
);
  localparam int CW = $clog2(BR);

  logic [CW-1:0] cnt;

  // Count 0..BR-1 and wrap; clr realigns the count to a new start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (clr || cnt == CW'(BR-1)) cnt <= '0;
    else                              cnt <= cnt + 1'b1;
  end

  assign mid = (cnt == CW'(BR/2));
  assign fin = (cnt == CW'(BR-1));
endmodule

// File: rtl/uart_cmd_slave.sv
// Two-byte UART command decoder driving a register bus, with a half-duplex
// single-frame read response.
module uart_cmd_slave
  import uart_cmd_slave_pkg::*;
#(
  parameter int BR           = 434,
  parameter int GAP          = 100,
  parameter int BYTE_TIMEOUT = 16*434
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic               tx,
  output logic               frame_err,
  output logic               busy,
  uart_cmd_slave_if.master   bus
);
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  state_t        state;
  logic          rx_s1, rx_s2, rx_prev;
  logic [7:0]    sh, b0, rdata;
  logic [2:0]    bit_idx;
  logic          par_bit, second;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  logic          start_edge, tmr_clr, mid, fin;

  // Start edge only counts while listening; rx is ignored during exec/response.
  assign start_edge = rx_prev & ~rx_s2;
  assign tmr_clr    = ((state == IDLE || state == WAIT_B1) && start_edge) ||
                      (state == TURN && gap_cnt == GW'(GAP-1));
  assign busy       = (state != IDLE);

  uart_bit_timer #(.BR(BR)) u_timer (
    .clk (clk), .rst (rst), .clr (tmr_clr), .mid (mid), .fin (fin)
  );

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Main controller: receive two frames, execute, optionally send response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tx            <= 1'b1;
      frame_err     <= 1'b0;
      bus.reg_we    <= 1'b0;
      bus.reg_re    <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      sh            <= '0;
      b0            <= '0;
      rdata         <= '0;
      bit_idx       <= '0;
      par_bit       <= 1'b0;
      second        <= 1'b0;
      gap_cnt       <= '0;
      to_cnt        <= '0;
    end else begin
      bus.reg_we <= 1'b0;
      bus.reg_re <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          second <= 1'b0;
          if (start_edge) state <= RX_START;
        end
        RX_START: if (mid) begin
          bit_idx <= '0;
          state   <= rx_s2 ? IDLE : RX_DATA;   // high at mid-bit: glitch
        end
        RX_DATA: if (mid) begin
          sh      <= {rx_s2, sh[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'(DATA_BITS-1)) state <= RX_PAR;
        end
        RX_PAR: if (mid) begin
          par_bit <= rx_s2;
          state   <= RX_STOP;
        end
        RX_STOP: if (mid) begin
          if (par_bit != odd_par(sh) || !rx_s2) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (!second) begin
            b0     <= sh;
            second <= 1'b1;
            to_cnt <= '0;
            state  <= WAIT_B1;
          end else begin
            bus.reg_addr  <= sh[6:0];
            bus.reg_wdata <= b0;
            bus.reg_we    <= sh[7];
            bus.reg_re    <= ~sh[7];
            state         <= EXEC;
          end
        end
        WAIT_B1: begin
          if (start_edge) begin
            state <= RX_START;
          end else if (to_cnt == TW'(BYTE_TIMEOUT-1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        EXEC:    state <= bus.reg_we ? IDLE : RD_WAIT;
        RD_WAIT: begin
          rdata   <= bus.reg_rdata;
          gap_cnt <= '0;
          state   <= TURN;
        end
        TURN: begin
          if (gap_cnt == GW'(GAP-1)) begin
            tx    <= 1'b0;
            state <= TX_START;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        TX_START: if (fin) begin
          tx      <= rdata[0];
          bit_idx <= '0;
          state   <= TX_DATA;
        end
        TX_DATA: if (fin) begin
          if (bit_idx == 3'(DATA_BITS-1)) begin
            tx    <= odd_par(rdata);
            state <= TX_PAR;
          end else begin
            tx      <= rdata[bit_idx + 3'd1];
            bit_idx <= bit_idx + 1'b1;
          end
        end
        TX_PAR: if (fin) begin
          tx    <= 1'b1;
          state <= TX_STOP;
        end
        TX_STOP: if (fin) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_slave.sv
// Bench for uart_cmd_slave: vector table, random commands, glitch and reset cases.
module tb_uart_cmd_slave;
  localparam int BR  = 120;
  localparam int MID = BR/2;
  localparam int GAP = 20;
  localparam int BT  = 16*BR;

  logic clk = 1'b0, rst = 1'b0, rx = 1'b1;
  logic tx, frame_err, busy;

  uart_cmd_slave_if bus();

  uart_cmd_slave #(.BR(BR), .GAP(GAP), .BYTE_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .frame_err(frame_err), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-bus responder: read data is valid only in the cycle after reg_re.
  logic [7:0] rd_val = 8'h00;
  always @(posedge clk) bus.reg_rdata <= bus.reg_re ? rd_val : ~rd_val;

  // Strobe / error monitor.
  int we_n = 0, re_n = 0, fe_n = 0, both_n = 0, ev_cyc = 0, fe_cyc = 0;
  logic [6:0] ev_addr = '0;
  logic [7:0] ev_wdata = '0;
  always @(negedge clk) if (!rst) begin
    if (bus.reg_we) begin
      we_n <= we_n + 1; ev_cyc <= cyc; ev_addr <= bus.reg_addr; ev_wdata <= bus.reg_wdata;
    end
    if (bus.reg_re) begin
      re_n <= re_n + 1; ev_cyc <= cyc; ev_addr <= bus.reg_addr;
    end
    if (bus.reg_we && bus.reg_re) both_n <= both_n + 1;
    if (frame_err) begin fe_n <= fe_n + 1; fe_cyc <= cyc; end
  end

  // Response-frame capture: sample each tx bit at its middle.
  int tx_n = 0, tx_cyc = 0;
  logic [10:0] tx_frame = '0;
  initial forever begin
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      tx_cyc = cyc;
      repeat (MID) @(negedge clk);
      tx_frame[0] = tx;
      for (int k = 1; k < 11; k++) begin
        repeat (BR) @(negedge clk);
        tx_frame[k] = tx;
      end
      tx_n++;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive one frame on rx; p returns the cycle index of the start bit.
  task automatic send_byte(input logic [7:0] b, input logic bad_par,
                           input logic bad_stop, output int p);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    @(posedge clk); #1;
    p = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (BR) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  // mode: 0 good, 1 bad parity byte1, 2 bad stop byte1,
  //       3 bad parity byte0 (byte0 only), 4 good byte0 then silence.
  task automatic do_txn(input logic [15:0] cmd, input logic [7:0] rd, input int mode,
                        input logic e_we, input logic e_re, input logic [6:0] e_addr,
                        input logic [7:0] e_wd, input logic e_fe,
                        input logic [10:0] e_frame, input string nm);
    int we0, re0, fe0, tx0, p, budget, fe_exp;
    we0 = we_n; re0 = re_n; fe0 = fe_n; tx0 = tx_n;
    rd_val = rd;
    send_byte(cmd[7:0], mode == 3, 1'b0, p);
    if (mode < 3) send_byte(cmd[15:8], mode == 1, mode == 2, p);
    fe_exp = p + 4 + 10*BR + MID + ((mode == 4) ? BT : 0);
    if (e_re) begin
      budget = 0;
      while (tx_n == tx0 && budget < 20*BR) begin @(negedge clk); budget++; end
      chk({nm, "_txcnt"}, tx_n - tx0, 1);
      chk({nm, "_frame"}, int'(tx_frame), int'(e_frame));
      chk({nm, "_txstart"}, tx_cyc - ev_cyc, GAP + 2);
      while (cyc < tx_cyc + 11*BR - 1) @(negedge clk);
      chk({nm, "_busy_stop"}, int'(busy), 1);
      @(negedge clk);
      chk({nm, "_busy_end"}, int'(busy), 0);
    end else begin
      repeat (2*BR + ((mode == 4) ? BT : 0)) @(negedge clk);
      chk({nm, "_busy_end"}, int'(busy), 0);
      chk({nm, "_txcnt"}, tx_n - tx0, 0);
    end
    chk({nm, "_we"}, we_n - we0, int'(e_we));
    chk({nm, "_re"}, re_n - re0, int'(e_re));
    chk({nm, "_fe"}, fe_n - fe0, int'(e_fe));
    if (e_we || e_re) begin
      chk({nm, "_addr"}, int'(ev_addr), int'(e_addr));
      chk({nm, "_exec_cyc"}, ev_cyc - p, 4 + 10*BR + MID);
    end
    if (e_we) chk({nm, "_wdata"}, int'(ev_wdata), int'(e_wd));
    if (e_fe) chk({nm, "_fe_cyc"}, fe_cyc, fe_exp);
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  rd;
    int          mode;
    logic        e_we, e_re;
    logic [6:0]  e_addr;
    logic [7:0]  e_wd;
    logic        e_fe;
    logic [10:0] e_frame;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int p, budget, we0, re0, fe0;
    logic [15:0] c;
    logic [7:0]  r;

    tbl[0] = '{16'h85A5, 8'h00, 0, 1'b1, 1'b0, 7'h05, 8'hA5, 1'b0, 11'h000};
    tbl[1] = '{16'h1200, 8'h3C, 0, 1'b0, 1'b1, 7'h12, 8'h00, 1'b0, 11'h678};
    tbl[2] = '{16'h85A5, 8'h00, 1, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 11'h000};
    tbl[3] = '{16'h8101, 8'h00, 2, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 11'h000};
    tbl[4] = '{16'h00A5, 8'h00, 3, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 11'h000};
    tbl[5] = '{16'h0033, 8'h00, 4, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 11'h000};
    tbl[6] = '{16'h7F00, 8'hFF, 0, 1'b0, 1'b1, 7'h7F, 8'h00, 1'b0, 11'h7FE};
    tbl[7] = '{16'hFF00, 8'h00, 0, 1'b1, 1'b0, 7'h7F, 8'h00, 1'b0, 11'h000};
    tbl[8] = '{16'h0000, 8'h00, 0, 1'b0, 1'b1, 7'h00, 8'h00, 1'b0, 11'h600};

    // Reset state.
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(bus.reg_we), 0);
    chk("rst_re", int'(bus.reg_re), 0);
    chk("rst_addr", int'(bus.reg_addr), 0);
    chk("rst_wdata", int'(bus.reg_wdata), 0);
    chk("rst_fe", int'(frame_err), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 9; i++)
      do_txn(tbl[i].cmd, tbl[i].rd, tbl[i].mode, tbl[i].e_we, tbl[i].e_re,
             tbl[i].e_addr, tbl[i].e_wd, tbl[i].e_fe, tbl[i].e_frame,
             $sformatf("vec%0d", i));

    // Random good commands against the command/frame model.
    for (int i = 0; i < 6; i++) begin
      c = 16'($urandom);
      r = 8'($urandom);
      do_txn(c, r, 0, c[15], ~c[15], c[14:8], c[7:0], 1'b0,
             {1'b1, ~^r, r, 1'b0}, $sformatf("rnd%0d_%04h", i, c));
    end

    // 50-cycle low glitch: back to IDLE at the start-bit mid sample.
    we0 = we_n; re0 = re_n; fe0 = fe_n;
    @(posedge clk); #1;
    p = cyc;
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1 rx = 1'b1;
    while (cyc < p + 3 + MID) @(negedge clk);
    chk("glitch_busy_hi", int'(busy), 1);
    @(negedge clk);
    chk("glitch_busy_lo", int'(busy), 0);
    repeat (BR) @(negedge clk);
    chk("glitch_fe", fe_n - fe0, 0);
    chk("glitch_strobes", (we_n - we0) + (re_n - re0), 0);

    // Reset in the middle of a read response, then a normal write.
    re0 = re_n;
    rd_val = 8'h3C;
    send_byte(8'h00, 1'b0, 1'b0, p);
    send_byte(8'h12, 1'b0, 1'b0, p);
    chk("rstx_re", re_n - re0, 1);
    budget = 0;
    while (cyc < ev_cyc + GAP + 2 + BR + MID && budget < 40*BR) begin
      @(negedge clk); budget++;
    end
    chk("rstx_pre_tx", int'(tx), 0);
    rst = 1'b1;
    #1;
    chk("rstx_tx", int'(tx), 1);
    chk("rstx_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (11*BR) @(negedge clk);
    do_txn(16'h8101, 8'h00, 0, 1'b1, 1'b0, 7'h01, 8'h01, 1'b0, 11'h000, "post_rst");

    chk("we_re_exclusive", both_n, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
